// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: time-shares one 1-bit full-adder cell
// over WIDTH cycles, LSB first, behind a start/ready/done handshake.

module serial_add_fa (
  input  logic ai,
  input  logic bi,
  input  logic ci,
  output logic f_c,
  output logic co_c
);
  assign f_c  = ai ^ bi ^ ci;
  assign co_c = (ai & bi) | (ci & (ai ^ bi));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             load, step, last;
  logic             fa_f, fa_c;

  serial_add_fa u_fa (
    .ai   (a_sh[0]),
    .bi   (b_sh[0]),
    .ci   (carry),
    .f_c  (fa_f),
    .co_c (fa_c)
  );

  // Next-state and datapath enables
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == S_IDLE);
      busy  <= (state_nxt == S_RUN);
      done  <= (state_nxt == S_DONE);
    end
  end

  // Result bits shift into a_sh's MSB as operand bits leave its LSB,
  // so a_sh holds the full result after WIDTH steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      a_sh  <= a;
      b_sh  <= b ^ {WIDTH{sub}};
      carry <= sub ? 1'b1 : cin;
    end else if (step) begin
      cnt   <= cnt + CW'(1);
      a_sh  <= {fa_f, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      carry <= fa_c;
      if (last) begin
        sum  <= {fa_f, a_sh[WIDTH-1:1]};
        cout <= fa_c;
        ovf  <= carry ^ fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl (WIDTH=8) against an
// arithmetic reference model.

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, sub, cin;
  logic [7:0] a, b;
  logic       ready, busy, done, cout, ovf;
  logic [7:0] sum;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ovf, cout, sum} from plain modular arithmetic and sign rules
  function automatic logic [9:0] ref_model(input logic [7:0] x, input logic [7:0] y,
                                           input logic s, input logic ci);
    logic [7:0] yb;
    logic [8:0] tot;
    logic [7:0] r;
    logic       v;
    yb  = s ? ~y : y;
    tot = {1'b0, x} + {1'b0, yb} + 9'(s ? 1'b1 : ci);
    r   = tot[7:0];
    v   = (x[7] == yb[7]) && (r[7] != x[7]);
    return {v, tot[8], r};
  endfunction

  function automatic logic [31:0] onehot3();
    return 32'(ready) + 32'(busy) + 32'(done);
  endfunction

  // One full operation with cycle-exact handshake and result checks
  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb,
                        input logic xs, input logic xc, input string tag);
    logic [9:0] exp;
    logic [7:0] prev;
    exp  = ref_model(xa, xb, xs, xc);
    prev = sum;
    chk({tag, "_ready_pre"}, 32'(ready), 1);
    a = xa; b = xb; sub = xs; cin = xc; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    for (int i = 1; i <= 8; i++) begin
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_nodone"}, 32'(done), 0);
      chk({tag, "_sum_hold"}, 32'(sum), 32'(prev));
      tick();
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_sum"}, 32'(sum), 32'(exp[7:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(exp[8]));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp[9]));
    tick();
    chk({tag, "_ready_post"}, 32'(ready), 1);
    chk({tag, "_done_post"}, 32'(done), 0);
    chk({tag, "_sum_post"}, 32'(sum), 32'(exp[7:0]));
  endtask

  initial begin
    logic [9:0] q[$];
    logic [9:0] got;
    int         last_acc;
    int         nacc;

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_done",  32'(done),  0);
    chk("rst_sum",   32'(sum),   0);
    chk("rst_cout",  32'(cout),  0);
    chk("rst_ovf",   32'(ovf),   0);
    tick();
    chk("idle_stay", 32'(ready), 1);

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, "t1_add");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "t2_wrap");
    run_op(8'h7F, 8'h00, 1'b0, 1'b1, "t2_ovf");
    run_op(8'h05, 8'h07, 1'b1, 1'b0, "t3_sub_borrow");
    run_op(8'h80, 8'h01, 1'b1, 1'b1, "t3_sub_ovf");

    // start held high with operands changing every cycle
    q.delete();
    nacc = 0; last_acc = 0;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      if (ready) begin
        q.push_back(ref_model(a, b, sub, cin));
        if (nacc > 0) chk("t4_period", 32'(cyc - last_acc), 10);
        last_acc = cyc;
        nacc++;
      end
      tick();
      chk("t4_onehot", onehot3(), 1);
      if (done) begin
        chk("t4_q_nonempty", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          got = q.pop_front();
          chk("t4_sum", 32'(sum), 32'(got[7:0]));
          chk("t4_cout", 32'(cout), 32'(got[8]));
          chk("t4_ovf", 32'(ovf), 32'(got[9]));
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done && q.size() > 0) begin
        got = q.pop_front();
        chk("t4_drain_sum", 32'(sum), 32'(got[7:0]));
      end
    end
    chk("t4_drained", 32'(q.size()), 0);
    chk("t4_accepts", 32'(nacc), 6);

    // reset in the fourth RUN cycle aborts the operation
    a = 8'h55; b = 8'h22; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("t5_busy_c4", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ready", 32'(ready), 1);
    chk("t5_busy",  32'(busy),  0);
    chk("t5_sum",   32'(sum),   0);
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nacc++;
      tick();
    end
    chk("t5_no_done", 32'(nacc), 0);
    run_op(8'h03, 8'h04, 1'b0, 1'b0, "t5_after");

    for (int n = 0; n < 1000; n++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "t6_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
